snax_hwpe_periph_arb: RTL and testbench

Round-robin arbiter that shares one HWPE peripheral (register-file) port among `NumReq` requesters, for example several `snax_hwpe_ctrl` bridges or a bridge plus a DMA-side configurator. Grants are combinational and single-cycle. An in-order tracking queue records which requester owns each outstanding transaction, so every `r_valid` response returns to the requester that issued it. It sits between the requester-side periph masters and the HWPE control slave.

---
 rtl/snax_hwpe_periph_arb.sv | 122 ++++++++++++
 tb/tb_snax_hwpe_periph_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/snax_hwpe_periph_arb.sv
// Round-robin arbiter sharing one HWPE peripheral port among NumReq requesters.
// An in-order tracking queue routes each response back to the requester that issued it.
module snax_hwpe_periph_arb #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumReq-1:0]          req_req_i,
  input  logic [NumReq*32-1:0]       req_add_i,
  input  logic [NumReq-1:0]          req_wen_i,
  input  logic [NumReq*4-1:0]        req_be_i,
  input  logic [NumReq*32-1:0]       req_data_i,
  input  logic [NumReq*IdWidth-1:0]  req_id_i,
  output logic [NumReq-1:0]          req_gnt_o,
  output logic [NumReq-1:0]          req_r_valid_o,
  output logic [31:0]                req_r_data_o,
  output logic [IdWidth-1:0]         req_r_id_o,
  output logic                       periph_req_o,
  output logic [31:0]                periph_add_o,
  output logic                       periph_wen_o,
  output logic [3:0]                 periph_be_o,
  output logic [31:0]                periph_data_o,
  output logic [IdWidth-1:0]         periph_id_o,
  input  logic                       periph_gnt_i,
  input  logic                       periph_r_valid_i,
  input  logic [31:0]                periph_r_data_i,
  input  logic [IdWidth-1:0]         periph_r_id_i,
  output logic                       busy_o,
  output logic                       spurious_o
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned QW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [PtrW-1:0] r_rr_ptr;
  logic [PtrW-1:0] r_queue [MaxOutstanding];
  logic [QW-1:0]   r_head;
  logic [QW-1:0]   r_tail;
  logic [CntW-1:0] r_count;

  logic            w_found;
  logic [PtrW-1:0] w_winner;
  logic [PtrW-1:0] w_rr_next;
  logic            w_full;
  logic            w_empty;
  logic            w_hs;
  logic            w_pop;
  int              w_idx;

  function automatic logic [QW-1:0] incPtr(input logic [QW-1:0] p);
    if (p == QW'(MaxOutstanding - 1)) return '0;
    return p + QW'(1);
  endfunction

  // Scan from the round-robin pointer upward; the first active request wins and drives the payload.
  always_comb begin
    w_found       = 1'b0;
    w_winner      = '0;
    w_idx         = 0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b0;
    periph_be_o   = '0;
    periph_data_o = '0;
    periph_id_o   = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      w_idx = i + int'(r_rr_ptr);
      if (w_idx >= int'(NumReq)) w_idx = w_idx - int'(NumReq);
      if (!w_found && req_req_i[w_idx]) begin
        w_found       = 1'b1;
        w_winner      = PtrW'(w_idx);
        periph_add_o  = req_add_i[w_idx*32 +: 32];
        periph_wen_o  = req_wen_i[w_idx];
        periph_be_o   = req_be_i[w_idx*4 +: 4];
        periph_data_o = req_data_i[w_idx*32 +: 32];
        periph_id_o   = req_id_i[w_idx*IdWidth +: IdWidth];
      end
    end
  end

  assign w_full    = (r_count == CntW'(MaxOutstanding));
  assign w_empty   = (r_count == '0);
  assign w_rr_next = (w_winner == PtrW'(NumReq - 1)) ? '0 : w_winner + PtrW'(1);

  // A pop in the same cycle does not relieve a full queue; the slot frees on the next cycle.
  assign periph_req_o = w_found & ~w_full & rst_ni;
  assign w_hs         = periph_req_o & periph_gnt_i;
  assign w_pop        = periph_r_valid_i & ~w_empty & rst_ni;

  assign req_gnt_o     = w_hs  ? (NumReq'(1) << w_winner)        : '0;
  assign req_r_valid_o = w_pop ? (NumReq'(1) << r_queue[r_head]) : '0;
  assign req_r_data_o  = periph_r_data_i;
  assign req_r_id_o    = periph_r_id_i;
  assign busy_o        = ~w_empty;
  assign spurious_o    = periph_r_valid_i & w_empty & rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
    end else begin
      if (w_hs) begin
        r_queue[r_tail] <= w_winner;
        r_tail          <= incPtr(r_tail);
        r_rr_ptr        <= w_rr_next;
      end
      if (w_pop) begin
        r_head <= incPtr(r_head);
      end
      if (w_hs && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_hs && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_snax_hwpe_periph_arb.sv
// Scoreboard bench for snax_hwpe_periph_arb: directed vectors push expectations,
// a negedge monitor pops and compares whenever grants or responses appear.
module tb_snax_hwpe_periph_arb;

  logic         clk;
  logic         rst_ni;
  logic [1:0]   req_req_i;
  logic [63:0]  req_add_i;
  logic [1:0]   req_wen_i;
  logic [7:0]   req_be_i;
  logic [63:0]  req_data_i;
  logic [9:0]   req_id_i;
  logic [1:0]   req_gnt_o;
  logic [1:0]   req_r_valid_o;
  logic [31:0]  req_r_data_o;
  logic [4:0]   req_r_id_o;
  logic         periph_req_o;
  logic [31:0]  periph_add_o;
  logic         periph_wen_o;
  logic [3:0]   periph_be_o;
  logic [31:0]  periph_data_o;
  logic [4:0]   periph_id_o;
  logic         periph_gnt_i;
  logic         periph_r_valid_i;
  logic [31:0]  periph_r_data_i;
  logic [4:0]   periph_r_id_i;
  logic         busy_o;
  logic         spurious_o;

  snax_hwpe_periph_arb #(.NumReq(2), .MaxOutstanding(4), .IdWidth(5)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_req_i(req_req_i), .req_add_i(req_add_i), .req_wen_i(req_wen_i),
    .req_be_i(req_be_i), .req_data_i(req_data_i), .req_id_i(req_id_i),
    .req_gnt_o(req_gnt_o), .req_r_valid_o(req_r_valid_o),
    .req_r_data_o(req_r_data_o), .req_r_id_o(req_r_id_o),
    .periph_req_o(periph_req_o), .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
    .periph_be_o(periph_be_o), .periph_data_o(periph_data_o), .periph_id_o(periph_id_o),
    .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
    .periph_r_data_i(periph_r_data_i), .periph_r_id_i(periph_r_id_i),
    .busy_o(busy_o), .spurious_o(spurious_o)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] rv;
    logic       req;
    logic       busy;
    logic       spur;
  } statExp_t;

  typedef struct packed {
    logic [31:0] add;
    logic [31:0] data;
    logic [4:0]  id;
    logic        wen;
  } gntExp_t;

  typedef struct packed {
    logic [1:0]  rv;
    logic [31:0] data;
    logic [4:0]  id;
  } rspExp_t;

  statExp_t statQ[$];
  gntExp_t  gntQ[$];
  rspExp_t  rspQ[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, record what the DUT must show this cycle, then advance.
  task automatic applyStimulus(input logic rstn, input logic [1:0] rq, input logic gnt,
                               input logic rv, input logic [31:0] rdata,
                               input logic [1:0] eGnt, input logic [1:0] eRv,
                               input logic eReq, input logic eBusy, input logic eSpur);
    gntExp_t g;
    rspExp_t r;
    statExp_t s;
    rst_ni           = rstn;
    req_req_i        = rq;
    periph_gnt_i     = gnt;
    periph_r_valid_i = rv;
    periph_r_data_i  = rdata;
    periph_r_id_i    = rdata[4:0];
    s = '{gnt: eGnt, rv: eRv, req: eReq, busy: eBusy, spur: eSpur};
    statQ.push_back(s);
    if (eGnt == 2'b01) begin
      g = '{add: 32'h10, data: 32'hA0A0A0A0, id: 5'd3, wen: 1'b1};
      gntQ.push_back(g);
    end else if (eGnt == 2'b10) begin
      g = '{add: 32'h24, data: 32'hB1B1B1B1, id: 5'd17, wen: 1'b0};
      gntQ.push_back(g);
    end
    if (eRv != 2'b00) begin
      r = '{rv: eRv, data: rdata, id: rdata[4:0]};
      rspQ.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  statExp_t mS;
  gntExp_t  mG;
  rspExp_t  mR;

  always @(negedge clk) begin
    if (statQ.size() > 0) begin
      mS = statQ.pop_front();
      checkOutput("gntVec",   {30'd0, req_gnt_o},     {30'd0, mS.gnt});
      checkOutput("rvalid",   {30'd0, req_r_valid_o}, {30'd0, mS.rv});
      checkOutput("periphReq", {31'd0, periph_req_o}, {31'd0, mS.req});
      checkOutput("busy",     {31'd0, busy_o},        {31'd0, mS.busy});
      checkOutput("spurious", {31'd0, spurious_o},    {31'd0, mS.spur});
    end
    if (req_gnt_o != 2'b00) begin
      if (gntQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedGnt actual=%b required=00 at %0t", req_gnt_o, $time);
      end else begin
        mG = gntQ.pop_front();
        checkOutput("gntAdd",  periph_add_o,  mG.add);
        checkOutput("gntData", periph_data_o, mG.data);
        checkOutput("gntId",   {27'd0, periph_id_o}, {27'd0, mG.id});
        checkOutput("gntWen",  {31'd0, periph_wen_o}, {31'd0, mG.wen});
      end
    end
    if (req_r_valid_o != 2'b00) begin
      if (rspQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedRsp actual=%b required=00 at %0t", req_r_valid_o, $time);
      end else begin
        mR = rspQ.pop_front();
        checkOutput("rspRoute", {30'd0, req_r_valid_o}, {30'd0, mR.rv});
        checkOutput("rspData",  req_r_data_o, mR.data);
        checkOutput("rspId",    {27'd0, req_r_id_o}, {27'd0, mR.id});
      end
    end
  end

  initial begin
    clk              = 1'b0;
    rst_ni           = 1'b0;
    req_req_i        = 2'b00;
    req_add_i        = {32'h24, 32'h10};
    req_wen_i        = 2'b01;
    req_be_i         = {4'h3, 4'hF};
    req_data_i       = {32'hB1B1B1B1, 32'hA0A0A0A0};
    req_id_i         = {5'd17, 5'd3};
    periph_gnt_i     = 1'b0;
    periph_r_valid_i = 1'b0;
    periph_r_data_i  = '0;
    periph_r_id_i    = '0;
    @(posedge clk);
    #1;

    // reset forces request/grant low
    applyStimulus(0, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // single request
    applyStimulus(1, 2'b01, 1, 0, 0,            2'b01, 2'b00, 1, 0, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'hDEADBEEF, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 0, 0,            2'b00, 2'b00, 0, 0, 0);

    // fairness from a fresh pointer, responses overlapping grants
    applyStimulus(0, 2'b00, 0, 0, 0,        2'b00, 2'b00, 0, 0, 0);
    applyStimulus(1, 2'b11, 1, 0, 0,        2'b01, 2'b00, 1, 0, 0);
    applyStimulus(1, 2'b11, 1, 1, 32'h101,  2'b10, 2'b01, 1, 1, 0);
    applyStimulus(1, 2'b11, 1, 1, 32'h102,  2'b01, 2'b10, 1, 1, 0);
    applyStimulus(1, 2'b11, 1, 1, 32'h103,  2'b10, 2'b01, 1, 1, 0);
    applyStimulus(1, 2'b11, 1, 1, 32'h104,  2'b01, 2'b10, 1, 1, 0);
    applyStimulus(1, 2'b11, 1, 1, 32'h105,  2'b10, 2'b01, 1, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'h106,  2'b00, 2'b10, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 0, 0,        2'b00, 2'b00, 0, 0, 0);

    // out-of-turn routing; a request without slave grant is not granted
    applyStimulus(1, 2'b11, 0, 0, 0,     2'b00, 2'b00, 1, 0, 0);
    applyStimulus(1, 2'b10, 1, 0, 0,     2'b10, 2'b00, 1, 0, 0);
    applyStimulus(1, 2'b01, 1, 0, 0,     2'b01, 2'b00, 1, 1, 0);
    applyStimulus(1, 2'b10, 1, 0, 0,     2'b10, 2'b00, 1, 1, 0);
    applyStimulus(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'hA, 2'b00, 2'b10, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'hB, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'hC, 2'b00, 2'b10, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 0, 0,     2'b00, 2'b00, 0, 0, 0);

    // full stall and recovery
    applyStimulus(1, 2'b01, 1, 0, 0,      2'b01, 2'b00, 1, 0, 0);
    applyStimulus(1, 2'b01, 1, 0, 0,      2'b01, 2'b00, 1, 1, 0);
    applyStimulus(1, 2'b01, 1, 0, 0,      2'b01, 2'b00, 1, 1, 0);
    applyStimulus(1, 2'b01, 1, 0, 0,      2'b01, 2'b00, 1, 1, 0);
    applyStimulus(1, 2'b01, 1, 0, 0,      2'b00, 2'b00, 0, 1, 0);
    applyStimulus(1, 2'b01, 1, 1, 32'h61, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b01, 1, 0, 0,      2'b01, 2'b00, 1, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'h71, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'h72, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'h73, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'h74, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 0, 0,      2'b00, 2'b00, 0, 0, 0);

    // spurious response with empty queue
    applyStimulus(1, 2'b00, 0, 1, 32'h55, 2'b00, 2'b00, 0, 0, 1);
    applyStimulus(1, 2'b00, 0, 0, 0,      2'b00, 2'b00, 0, 0, 0);

    // reset with two outstanding transactions
    applyStimulus(1, 2'b11, 1, 0, 0,      2'b10, 2'b00, 1, 0, 0);
    applyStimulus(1, 2'b11, 1, 0, 0,      2'b01, 2'b00, 1, 1, 0);
    applyStimulus(0, 2'b11, 1, 0, 0,      2'b00, 2'b00, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'h77, 2'b00, 2'b00, 0, 0, 1);
    applyStimulus(1, 2'b11, 1, 0, 0,      2'b01, 2'b00, 1, 0, 0);
    applyStimulus(1, 2'b00, 0, 1, 32'h88, 2'b00, 2'b01, 0, 1, 0);
    applyStimulus(1, 2'b00, 0, 0, 0,      2'b00, 2'b00, 0, 0, 0);

    checkOutput("gntQDrained", gntQ.size(), 0);
    checkOutput("rspQDrained", rspQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
